// File: rtl/rvv_pkg.sv
// rtl/rvv_pkg.sv - shared encodings for the vector lane collector
package rvv_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } state_t;

  localparam logic [2:0] VSEW_E8  = 3'd0;
  localparam logic [2:0] VSEW_E16 = 3'd1;
  localparam logic [2:0] VSEW_E32 = 3'd2;
  localparam logic [2:0] VSEW_E64 = 3'd3;

  localparam int IDX_W     = 17;
  localparam int WB_ADDR_W = 5;
endpackage

// File: rtl/rvv_lane_merge.sv
// rtl/rvv_lane_merge.sv - per-lane write enable and VLEN-wide placement of one result chunk
module rvv_lane_merge
  import rvv_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3
) (
  input  logic [2:0]                  vsew,
  input  logic [IDX_W-1:0]            vl,
  input  logic                        mask_en,
  input  logic [VLEN-1:0]             v0,
  input  logic                        valid,
  input  logic [IDX_W-1:0]            idx,
  input  logic [3:0]                  in_reg_offset,
  input  logic [(1<<LANE_WIDTH)-1:0]  data,
  output logic [VLEN-1:0]             wmask,
  output logic [VLEN-1:0]             wdata
);
  localparam int LW    = 1 << LANE_WIDTH;
  localparam int VIDXW = $clog2(VLEN);

  logic [31:0]     sew;
  logic [31:0]     cw;
  logic [31:0]     pos;
  logic            mask_bit;
  logic            en;
  logic [VLEN-1:0] chunk_mask;
  logic [VLEN-1:0] chunk_data;

  always_comb begin
    sew = 32'd8 << vsew;
    cw  = (sew < 32'(LW)) ? sew : 32'(LW);
    // Sub-element chunk offset only matters when an element spans several lane beats
    pos = 32'(idx) * sew + ((sew > 32'(LW)) ? 32'(in_reg_offset) * 32'(LW) : 32'd0);
    mask_bit = (32'(idx) < 32'(VLEN)) ? v0[idx[VIDXW-1:0]] : 1'b0;
    en = valid && (idx < vl) && (!mask_en || mask_bit) && (pos + cw <= 32'(VLEN));

    chunk_mask = '0;
    chunk_data = '0;
    for (int b = 0; b < LW; b++) begin
      if (32'(b) < cw) begin
        chunk_mask[b] = 1'b1;
        chunk_data[b] = data[b];
      end
    end

    wmask = en ? (chunk_mask << pos) : '0;
    wdata = en ? (chunk_data << pos) : '0;
  end
endmodule

// File: rtl/rvv_lane_collector.sv
// rtl/rvv_lane_collector.sv - merges lane results into a destination buffer and writes it back
module rvv_lane_collector
  import rvv_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3,
  parameter int NB_LANES   = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [2:0]               vsew,
  input  logic [IDX_W-1:0]         vl,
  input  logic                     mask_en,
  input  logic [WB_ADDR_W-1:0]     vd_addr,
  input  logic [VLEN-1:0]          old_vd,
  input  logic [VLEN-1:0]          v0,
  input  logic [64*(1<<NB_LANES)-1:0]    lane_vd,
  input  logic [IDX_W*(1<<NB_LANES)-1:0] lane_idx,
  input  logic [(1<<NB_LANES)-1:0] lane_valid,
  input  logic [3:0]               in_reg_offset,
  input  logic                     alu_done,
  output logic                     busy,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [WB_ADDR_W-1:0]     wb_addr,
  output logic [VLEN-1:0]          wb_data,
  output logic                     done
);
  localparam int L  = 1 << NB_LANES;
  localparam int LW = 1 << LANE_WIDTH;

  state_t               state;
  logic [VLEN-1:0]      buffer;
  logic [VLEN-1:0]      buf_next;
  logic [2:0]           vsew_q;
  logic [IDX_W-1:0]     vl_q;
  logic                 mask_q;
  logic [VLEN-1:0]      v0_q;
  logic [WB_ADDR_W-1:0] addr_q;
  logic [VLEN-1:0]      wmask [L];
  logic [VLEN-1:0]      wdata [L];

  for (genvar g = 0; g < L; g++) begin : g_lane
    rvv_lane_merge #(
      .VLEN       (VLEN),
      .LANE_WIDTH (LANE_WIDTH)
    ) u_merge (
      .vsew          (vsew_q),
      .vl            (vl_q),
      .mask_en       (mask_q),
      .v0            (v0_q),
      .valid         (lane_valid[g]),
      .idx           (lane_idx[IDX_W*g +: IDX_W]),
      .in_reg_offset (in_reg_offset),
      .data          (lane_vd[64*g +: LW]),
      .wmask         (wmask[g]),
      .wdata         (wdata[g])
    );
    if (LW < 64) begin : g_spare
      logic spare_unused;
      assign spare_unused = ^lane_vd[64*g+LW +: 64-LW];
    end
  end

  // Lanes target disjoint bits, so sequential folding is order-independent
  always_comb begin
    buf_next = buffer;
    for (int k = 0; k < L; k++) begin
      buf_next = (buf_next & ~wmask[k]) | wdata[k];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      buffer   <= '0;
      vsew_q   <= '0;
      vl_q     <= '0;
      mask_q   <= 1'b0;
      v0_q     <= '0;
      addr_q   <= '0;
      busy     <= 1'b0;
      wb_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            buffer <= old_vd;
            vsew_q <= vsew;
            vl_q   <= vl;
            mask_q <= mask_en;
            v0_q   <= v0;
            addr_q <= vd_addr;
            busy   <= 1'b1;
            state  <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          buffer <= buf_next;
          if (alu_done) begin
            wb_valid <= 1'b1;
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          wb_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb_addr = addr_q;
  assign wb_data = buffer;
endmodule
